// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared CPU definitions: opcodes, ALU operation codes, control FSM states
// and default bus widths used by the fetch/decode/control stage.
package cpu_pkg;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_INSTR_W = 8;

    // Instruction opcodes (IR[7:4]); 8..E are undefined
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_WAIT = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation codes driven to the accumulator datapath
    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_PASS = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_decode_ctrl_if.sv
// Bundle of the PC, instruction-memory, ALU-control and status signals that
// connect the fetch/decode/control stage to the rest of the CPU.
interface fetch_decode_ctrl_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);

    logic [ADDR_W-1:0]  pc_in;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               zero_flag;
    logic               busy;
    logic               jump_flag;
    logic [ADDR_W-1:0]  jump_addr;
    logic [2:0]         alu_op;
    logic [3:0]         imm;
    logic               reg_we;
    logic               halted;
    logic               illegal_op;

    // CPU environment side: PC, ROM and ALU
    modport master (
        output pc_in, imem_data, zero_flag,
        input  imem_addr, busy, jump_flag, jump_addr, alu_op, imm,
               reg_we, halted, illegal_op
    );

    // Fetch/decode/control stage side
    modport slave (
        input  pc_in, imem_data, zero_flag,
        output imem_addr, busy, jump_flag, jump_addr, alu_op, imm,
               reg_we, halted, illegal_op
    );

endinterface

// File: rtl/fetch_decode_ctrl_instr_decode.sv
// Pure combinational instruction decoder: maps the IR (and zero flag for JZ)
// to ALU controls and the control-flow class of the instruction.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic [INSTR_W-1:0] i_ir,
    input  logic               i_zero_flag,
    output logic [2:0]         o_alu_op,
    output logic               o_reg_we,
    output logic               o_is_jump,
    output logic               o_is_wait,
    output logic               o_is_halt,
    output logic               o_illegal
);

    logic [3:0] w_opcode;
    logic [3:0] w_operand;

    assign w_opcode  = i_ir[7:4];
    assign w_operand = i_ir[3:0];

    // Decode the opcode; WAIT 0 and a not-taken JZ collapse to NOP
    always_comb begin
        o_alu_op  = ALU_NONE;
        o_reg_we  = 1'b0;
        o_is_jump = 1'b0;
        o_is_wait = 1'b0;
        o_is_halt = 1'b0;
        o_illegal = 1'b0;
        case (w_opcode)
            OP_NOP:  ;
            OP_LDI:  begin o_alu_op = ALU_PASS; o_reg_we = 1'b1; end
            OP_ADD:  begin o_alu_op = ALU_ADD;  o_reg_we = 1'b1; end
            OP_SUB:  begin o_alu_op = ALU_SUB;  o_reg_we = 1'b1; end
            OP_AND:  begin o_alu_op = ALU_AND;  o_reg_we = 1'b1; end
            OP_JMP:  o_is_jump = 1'b1;
            OP_JZ:   o_is_jump = i_zero_flag;
            OP_WAIT: o_is_wait = (w_operand != 4'd0);
            OP_HALT: o_is_halt = 1'b1;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode/control stage: registers the fetched word into the IR,
// executes it one cycle later, and steers the PC via busy/jump_flag.
// A taken jump squashes the single wrong-path word already fetched.
module fetch_decode_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic                clk,
    input  logic                rst,
    fetch_decode_ctrl_if.slave  bus
);

    state_e             r_state;
    state_e             w_stateNext;
    logic [INSTR_W-1:0] r_ir;
    logic               r_squash;
    logic               w_squashNext;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cntNext;

    logic               w_busy;
    logic               w_jumpFlag;
    logic [2:0]         w_aluOp;
    logic               w_regWe;
    logic               w_halted;
    logic               w_illegal;

    logic [2:0]         w_decAluOp;
    logic               w_decRegWe;
    logic               w_decJump;
    logic               w_decWait;
    logic               w_decHalt;
    logic               w_decIllegal;

    instr_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .i_ir        (r_ir),
        .i_zero_flag (bus.zero_flag),
        .o_alu_op    (w_decAluOp),
        .o_reg_we    (w_decRegWe),
        .o_is_jump   (w_decJump),
        .o_is_wait   (w_decWait),
        .o_is_halt   (w_decHalt),
        .o_illegal   (w_decIllegal)
    );

    // Next-state and output logic; decoded controls only reach the outputs
    // when the IR holds a live (non-squashed) instruction in RUN
    always_comb begin
        w_stateNext  = r_state;
        w_squashNext = r_squash;
        w_cntNext    = r_cnt;
        w_busy       = 1'b0;
        w_jumpFlag   = 1'b0;
        w_aluOp      = ALU_NONE;
        w_regWe      = 1'b0;
        w_halted     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (r_squash) begin
                    w_squashNext = 1'b0;
                end else begin
                    w_aluOp    = w_decAluOp;
                    w_regWe    = w_decRegWe;
                    w_jumpFlag = w_decJump;
                    w_illegal  = w_decIllegal;
                    if (w_decJump) begin
                        w_squashNext = 1'b1;
                    end
                    if (w_decWait) begin
                        w_busy      = 1'b1;
                        w_cntNext   = r_ir[3:0] - 4'd1;
                        w_stateNext = ST_STALL;
                    end
                    if (w_decHalt) begin
                        w_busy      = 1'b1;
                        w_stateNext = ST_HALTED;
                    end
                end
            end
            ST_STALL: begin
                if (r_cnt != 4'd0) begin
                    w_busy    = 1'b1;
                    w_cntNext = r_cnt - 4'd1;
                end else begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_HALTED: begin
                w_busy   = 1'b1;
                w_halted = 1'b1;
            end
            default: w_stateNext = ST_RUN;
        endcase
    end

    // State, squash and counter registers; the IR refills whenever the PC moves
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_ir     <= '0;
            r_squash <= 1'b0;
            r_cnt    <= 4'd0;
        end else begin
            r_state  <= w_stateNext;
            r_squash <= w_squashNext;
            r_cnt    <= w_cntNext;
            if (!w_busy) begin
                r_ir <= bus.imem_data;
            end
        end
    end

    assign bus.imem_addr  = bus.pc_in;
    assign bus.busy       = w_busy;
    assign bus.jump_flag  = w_jumpFlag;
    assign bus.jump_addr  = w_jumpFlag ? ADDR_W'(r_ir[3:0]) : '0;
    assign bus.alu_op     = w_aluOp;
    assign bus.imm        = (w_aluOp != ALU_NONE) ? r_ir[3:0] : 4'd0;
    assign bus.reg_we     = w_regWe;
    assign bus.halted     = w_halted;
    assign bus.illegal_op = w_illegal;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Testbench for fetch_decode_ctrl: a PC register obeying the PC contract and
// a 16x8 ROM close the loop around the stage; each scenario compares the
// full output bundle (plus pc_in) against hand-derived per-cycle vectors.
module tb_fetch_decode_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rom [16];
    logic [3:0] pcReg;
    logic       zeroFlag = 1'b0;

    int nChecks = 0;
    int nPassed = 0;

    fetch_decode_ctrl_if bus ();

    fetch_decode_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // PC block: reset, then jump, then increment when not busy, else hold
    always @(posedge clk) begin
        if (rst)                pcReg <= 4'd0;
        else if (bus.jump_flag) pcReg <= bus.jump_addr;
        else if (!bus.busy)     pcReg <= pcReg + 4'd1;
    end

    assign bus.pc_in     = pcReg;
    assign bus.imem_data = rom[bus.imem_addr];
    assign bus.zero_flag = zeroFlag;

    // Observed bundle: pc, busy, jf, ja, alu, imm, we, halted, illegal
    wire [19:0] obs = {bus.pc_in, bus.busy, bus.jump_flag, bus.jump_addr,
                       bus.alu_op, bus.imm, bus.reg_we, bus.halted, bus.illegal_op};

    function automatic logic [19:0] ex(input logic [3:0] pc, input logic busy,
                                       input logic jf, input logic [3:0] ja,
                                       input logic [2:0] alu, input logic [3:0] imm,
                                       input logic we, input logic h, input logic ill);
        return {pc, busy, jf, ja, alu, imm, we, h, ill};
    endfunction

    function automatic string fmt(input logic [19:0] v);
        return $sformatf("pc=%h busy=%b jf=%b ja=%h alu=%0d imm=%h we=%b halt=%b ill=%b",
                         v[19:16], v[15], v[14], v[13:10], v[9:7], v[6:3], v[2], v[1], v[0]);
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    // Pulse reset across exactly one rising edge; returns in the first cycle after reset
    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clearRom();
        resetDut();
        nChecks++;
        if (obs !== ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0))
            $display("FAIL reset: got %s, expected %s", fmt(obs),
                     fmt(ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0)));
        else nPassed++;
    endtask

    task automatic test_straight_line();
        logic [19:0] e [6];
        clearRom();
        rom[0] = 8'h13; rom[1] = 8'h22; rom[2] = 8'h31; rom[3] = 8'h45;
        e = '{ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 0, 0, 4'h0, 1, 4'h3, 1, 0, 0),
              ex(4'h2, 0, 0, 4'h0, 2, 4'h2, 1, 0, 0),
              ex(4'h3, 0, 0, 4'h0, 3, 4'h1, 1, 0, 0),
              ex(4'h4, 0, 0, 4'h0, 4, 4'h5, 1, 0, 0),
              ex(4'h5, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0)};
        resetDut();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (obs !== e[i])
                $display("FAIL straight c%0d: got %s, expected %s", i, fmt(obs), fmt(e[i]));
            else nPassed++;
        end
    endtask

    task automatic test_jump_squash();
        logic [19:0] e [5];
        clearRom();
        rom[0] = 8'h5A; rom[1] = 8'h14; rom[10] = 8'h27;
        e = '{ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 0, 1, 4'hA, 0, 4'h0, 0, 0, 0),
              ex(4'hA, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'hB, 0, 0, 4'h0, 2, 4'h7, 1, 0, 0),
              ex(4'hC, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0)};
        resetDut();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (obs !== e[i])
                $display("FAIL jmp c%0d: got %s, expected %s", i, fmt(obs), fmt(e[i]));
            else nPassed++;
        end
    endtask

    task automatic test_jz();
        logic [19:0] e [4];
        clearRom();
        rom[0] = 8'h6C; rom[1] = 8'h14;
        // Not taken: JZ is a NOP and LDI 4 follows normally
        zeroFlag = 1'b0;
        e = '{ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h2, 0, 0, 4'h0, 1, 4'h4, 1, 0, 0),
              ex(4'h3, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0)};
        resetDut();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (obs !== e[i])
                $display("FAIL jz0 c%0d: got %s, expected %s", i, fmt(obs), fmt(e[i]));
            else nPassed++;
        end
        // Taken: jump to C, wrong-path LDI 4 squashed
        zeroFlag = 1'b1;
        e = '{ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 0, 1, 4'hC, 0, 4'h0, 0, 0, 0),
              ex(4'hC, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'hD, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0)};
        resetDut();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (obs !== e[i])
                $display("FAIL jz1 c%0d: got %s, expected %s", i, fmt(obs), fmt(e[i]));
            else nPassed++;
        end
        zeroFlag = 1'b0;
    endtask

    task automatic test_wait();
        logic [19:0] e [7];
        logic [19:0] w [3];
        clearRom();
        rom[0] = 8'h73; rom[1] = 8'h11;
        e = '{ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h2, 0, 0, 4'h0, 1, 4'h1, 1, 0, 0),
              ex(4'h3, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0)};
        resetDut();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (obs !== e[i])
                $display("FAIL wait3 c%0d: got %s, expected %s", i, fmt(obs), fmt(e[i]));
            else nPassed++;
        end
        // WAIT 0 is a single-cycle NOP
        rom[0] = 8'h70;
        w = '{ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h2, 0, 0, 4'h0, 1, 4'h1, 1, 0, 0)};
        resetDut();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (obs !== w[i])
                $display("FAIL wait0 c%0d: got %s, expected %s", i, fmt(obs), fmt(w[i]));
            else nPassed++;
        end
    endtask

    task automatic test_halt_reset();
        logic [19:0] e [8];
        logic [19:0] r [2];
        logic [19:0] s [4];
        clearRom();
        rom[0] = 8'h13; rom[1] = 8'h22; rom[2] = 8'hF0;
        e = '{ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 0, 0, 4'h0, 1, 4'h3, 1, 0, 0),
              ex(4'h2, 0, 0, 4'h0, 2, 4'h2, 1, 0, 0),
              ex(4'h3, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h3, 1, 0, 4'h0, 0, 4'h0, 0, 1, 0),
              ex(4'h3, 1, 0, 4'h0, 0, 4'h0, 0, 1, 0),
              ex(4'h3, 1, 0, 4'h0, 0, 4'h0, 0, 1, 0),
              ex(4'h3, 1, 0, 4'h0, 0, 4'h0, 0, 1, 0)};
        resetDut();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (obs !== e[i])
                $display("FAIL halt c%0d: got %s, expected %s", i, fmt(obs), fmt(e[i]));
            else nPassed++;
        end
        // One reset edge leaves HALTED and fetch restarts from 0
        r = '{ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 0, 0, 4'h0, 1, 4'h3, 1, 0, 0)};
        resetDut();
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (obs !== r[i])
                $display("FAIL halt_rst c%0d: got %s, expected %s", i, fmt(obs), fmt(r[i]));
            else nPassed++;
        end
        // Reset while stalled in WAIT 5, then WAIT 5 runs again from RUN
        clearRom();
        rom[0] = 8'h75; rom[1] = 8'h11;
        resetDut();
        repeat (3) @(negedge clk);
        nChecks++;
        if (obs !== ex(4'h1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0))
            $display("FAIL wait5 stall: got %s, expected %s", fmt(obs),
                     fmt(ex(4'h1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0)));
        else nPassed++;
        s = '{ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0),
              ex(4'h1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0)};
        resetDut();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (obs !== s[i])
                $display("FAIL stall_rst c%0d: got %s, expected %s", i, fmt(obs), fmt(s[i]));
            else nPassed++;
        end
    endtask

    task automatic test_illegal_wrap();
        logic [19:0] expv;
        clearRom();
        rom[0] = 8'h13; rom[15] = 8'h9F;
        resetDut();
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1 || i == 17)  expv = ex(4'h1, 0, 0, 4'h0, 1, 4'h3, 1, 0, 0);
            else if (i == 16)       expv = ex(4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 1);
            else                    expv = ex(4'(i), 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
            nChecks++;
            if (obs !== expv)
                $display("FAIL illegal_wrap c%0d: got %s, expected %s", i, fmt(obs), fmt(expv));
            else nPassed++;
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_jump_squash();
        test_jz();
        test_wait();
        test_halt_reset();
        test_illegal_wrap();
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
